// File: rtl/dmem_lsu.sv
// dmem_lsu -- single-port data memory with a load/store unit front end.
//
// Holds 2**AW 32-bit words, byte addressed and little endian. It accepts one
// request per cycle and has no back-pressure. Stores write only the lanes
// selected by size and addr[1:0]. Loads return the selected byte, half or
// word one cycle after acceptance. The result is shifted down to bit 0 and
// then sign- or zero-extended. A misaligned or illegal request is rejected:
// memory is left unchanged and a one-cycle fault pulse is raised.
//
// With CLEAR_ON_RESET=1, the block sweeps zeros through every word after
// reset. It writes one word per cycle and holds ready low while it does so.
//
// Ports:
//   clk     rising-edge clock for all state
//   rst_n   asynchronous active-low reset
//   req     access request, taken when req && ready
//   we      1 = store, 0 = load
//   addr    byte address (word index addr[AW+1:2], lane addr[1:0])
//   size    00 byte, 01 half, 10 word, 11 illegal
//   uns     loads: 1 = zero-extend, 0 = sign-extend
//   wdata   right-aligned store data
//   ready   request can be accepted this cycle
//   rvalid  one-cycle pulse, rdata carries a load result
//   rdata   extended load result, held while rvalid is low
//   fault   one-cycle pulse, request was rejected
module dmem_lsu #(
   parameter int AW             = 10,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req,
   input  logic          we,
   input  logic [AW+1:0] addr,
   input  logic [1:0]    size,
   input  logic          uns,
   input  logic [31:0]   wdata,
   output logic          ready,
   output logic          rvalid,
   output logic [31:0]   rdata,
   output logic          fault
);

   localparam int DEPTH = 1 << AW;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam state_t          ST_RESET = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
   localparam logic [AW-1:0]   CNT_ONE  = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [AW-1:0]   CNT_LAST = {AW{1'b1}};

   // Returns 1 for an illegal size, or for a size whose alignment the lane
   // offset breaks.
   function automatic logic is_illegal(input logic [1:0] sz, input logic [1:0] lane);
      logic bad;
      case (sz)
         2'b00:   bad = 1'b0;
         2'b01:   bad = lane[0];
         2'b10:   bad = (lane != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   // Byte enables for a store. Lane 0 holds bits [7:0].
   function automatic logic [3:0] store_ben(input logic [1:0] sz, input logic [1:0] lane);
      logic [3:0] ben;
      case (sz)
         2'b00:   ben = 4'b0001 << lane;
         2'b01:   ben = lane[1] ? 4'b1100 : 4'b0011;
         2'b10:   ben = 4'b1111;
         default: ben = 4'b0000;
      endcase
      return ben;
   endfunction

   // Replicates right-aligned store data into every lane. The byte enables
   // then pick which copy lands.
   function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] d);
      logic [31:0] w;
      case (sz)
         2'b00:   w = {4{d[7:0]}};
         2'b01:   w = {2{d[15:0]}};
         default: w = d;
      endcase
      return w;
   endfunction

   // Shifts the addressed lane down to bit 0, then extends it.
   function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] lane,
                                            input logic [1:0] sz, input logic u);
      logic [31:0] sh;
      logic [31:0] r;
      sh = word >> {lane, 3'b000};
      case (sz)
         2'b00:   r = u ? {24'h000000, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
         2'b01:   r = u ? {16'h0000, sh[15:0]}   : {{16{sh[15]}}, sh[15:0]};
         default: r = word;
      endcase
      return r;
   endfunction

   state_t        state_r;
   state_t        state_next_s;
   logic [AW-1:0] cnt_r;
   logic          sweep_s;
   logic          ready_next_s;
   logic          ready_r;
   logic          rvalid_r;
   logic          fault_r;
   logic [31:0]   rdata_r;

   logic          accept_s;
   logic          illegal_s;
   logic [AW-1:0] word_idx_s;
   logic [1:0]    lane_s;

   logic          mem_we_s;
   logic [AW-1:0] mem_idx_s;
   logic [31:0]   mem_data_s;
   logic [3:0]    mem_ben_s;
   logic [31:0]   mem_r [0:DEPTH-1];

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_RESET;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next state: leave INIT on the same edge that writes the last word.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_INIT: begin
            if (cnt_r == CNT_LAST) begin
               state_next_s = ST_RUN;
            end else begin
               state_next_s = ST_INIT;
            end
         end
         ST_RUN:  state_next_s = ST_RUN;
         default: state_next_s = ST_RESET;
      endcase
   end

   // FSM outputs: sweep enable, and the value ready takes after this edge.
   always_comb begin
      sweep_s      = 1'b0;
      ready_next_s = 1'b0;
      case (state_r)
         ST_INIT: begin
            sweep_s      = 1'b1;
            ready_next_s = (cnt_r == CNT_LAST);
         end
         ST_RUN: begin
            sweep_s      = 1'b0;
            ready_next_s = 1'b1;
         end
         default: begin
            sweep_s      = 1'b0;
            ready_next_s = 1'b0;
         end
      endcase
   end

   // Sweep counter. It wraps back to zero as the sweep finishes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {AW{1'b0}};
      end else if (sweep_s) begin
         cnt_r <= cnt_r + CNT_ONE;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Registered ready. It is low throughout reset and rises on the edge that
   // enters RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_r <= 1'b0;
      end else begin
         ready_r <= ready_next_s;
      end
   end

   // Request decode.
   always_comb begin
      accept_s   = req & ready_r;
      illegal_s  = is_illegal(size, addr[1:0]);
      word_idx_s = addr[AW+1:2];
      lane_s     = addr[1:0];
   end

   // Memory write port. The sweep owns the port while ready is low, so it
   // never competes with a store.
   always_comb begin
      mem_we_s   = 1'b0;
      mem_idx_s  = {AW{1'b0}};
      mem_data_s = 32'h0000_0000;
      mem_ben_s  = 4'b0000;
      if (sweep_s) begin
         mem_we_s   = 1'b1;
         mem_idx_s  = cnt_r;
         mem_data_s = 32'h0000_0000;
         mem_ben_s  = 4'b1111;
      end else if (accept_s && we && !illegal_s) begin
         mem_we_s   = 1'b1;
         mem_idx_s  = word_idx_s;
         mem_data_s = store_data(size, wdata);
         mem_ben_s  = store_ben(size, lane_s);
      end else begin
         mem_we_s   = 1'b0;
         mem_idx_s  = word_idx_s;
         mem_data_s = 32'h0000_0000;
         mem_ben_s  = 4'b0000;
      end
   end

   // Memory array with per-lane write enables. Contents are not reset.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_ben_s[b]) begin
               mem_r[mem_idx_s][8*b +: 8] <= mem_data_s[8*b +: 8];
            end
         end
      end
   end

   // Response registers. A store on the previous edge is already in mem_r,
   // so a load right behind it sees post-store data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid_r <= 1'b0;
         fault_r  <= 1'b0;
         rdata_r  <= 32'h0000_0000;
      end else begin
         rvalid_r <= accept_s & ~we & ~illegal_s;
         fault_r  <= accept_s & illegal_s;
         if (accept_s && !we && !illegal_s) begin
            rdata_r <= load_ext(mem_r[word_idx_s], lane_s, size, uns);
         end
      end
   end

   assign ready  = ready_r;
   assign rvalid = rvalid_r;
   assign fault  = fault_r;
   assign rdata  = rdata_r;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu -- self-checking bench for dmem_lsu (AW=4, CLEAR_ON_RESET=1).
//
// The reference model is a byte array with little-endian access arithmetic.
// Each cycle the bench predicts ready, rvalid, fault and rdata, and a single
// check task compares them against the design.
module tb_dmem_lsu;

   localparam int AW    = 4;
   localparam int NWORD = 1 << AW;
   localparam int NBYTE = 4 * NWORD;

   logic          clk;
   logic          rst_n;
   logic          req;
   logic          we;
   logic [AW+1:0] addr;
   logic [1:0]    size;
   logic          uns;
   logic [31:0]   wdata;
   logic          ready;
   logic          rvalid;
   logic [31:0]   rdata;
   logic          fault;

   dmem_lsu #(.AW(AW), .CLEAR_ON_RESET(1)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req),
      .we     (we),
      .addr   (addr),
      .size   (size),
      .uns    (uns),
      .wdata  (wdata),
      .ready  (ready),
      .rvalid (rvalid),
      .rdata  (rdata),
      .fault  (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   bit [7:0]    mem_m [NBYTE];
   int          init_left;
   bit [31:0]   exp_rdata;
   bit          exp_rvalid;
   bit          exp_fault;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit model_illegal(input int a, input int s);
      return (s == 3) || (s == 1 && (a % 2) != 0) || (s == 2 && (a % 4) != 0);
   endfunction

   function automatic bit [31:0] model_load(input int a, input int s, input bit u);
      bit [31:0] v;
      if (s == 0) begin
         v = 32'(mem_m[a]);
         if (!u && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end else if (s == 1) begin
         v = 32'(mem_m[a]) + 32'd256 * 32'(mem_m[a+1]);
         if (!u && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end else begin
         v = 32'(mem_m[a]) + 32'd256 * 32'(mem_m[a+1])
           + 32'd65536 * 32'(mem_m[a+2]) + 32'd16777216 * 32'(mem_m[a+3]);
      end
      return v;
   endfunction

   task automatic model_store(input int a, input int s, input bit [31:0] d);
      int n;
      n = (s == 0) ? 1 : (s == 1) ? 2 : 4;
      for (int i = 0; i < n; i++) mem_m[a+i] = d[8*i +: 8];
   endtask

   // One clock cycle: drive at the negedge, then predict and compare just
   // after the posedge.
   task automatic step(input bit r, input bit w, input bit [5:0] a, input bit [1:0] s,
                       input bit u, input bit [31:0] d);
      bit rdy_b;
      @(negedge clk);
      req = r; we = w; addr = a; size = s; uns = u; wdata = d;
      rdy_b = (init_left == 0);
      @(posedge clk);
      #1;
      if (init_left > 0) init_left--;
      exp_rvalid = 1'b0;
      exp_fault  = 1'b0;
      if (r && rdy_b) begin
         if (model_illegal(int'(a), int'(s))) exp_fault = 1'b1;
         else if (w) model_store(int'(a), int'(s), d);
         else begin
            exp_rvalid = 1'b1;
            exp_rdata  = model_load(int'(a), int'(s), u);
         end
      end
      check("ready",  32'(ready),  32'(init_left == 0));
      check("rvalid", 32'(rvalid), 32'(exp_rvalid));
      check("fault",  32'(fault),  32'(exp_fault));
      check("rdata",  rdata,       exp_rdata);
   endtask

   // Asserts reset now, with no clock alignment, and checks that the outputs
   // clear at once. It releases reset just after the next posedge.
   task automatic do_reset();
      req   = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_ready",  32'(ready),  32'd0);
      check("rst_rvalid", 32'(rvalid), 32'd0);
      check("rst_fault",  32'(fault),  32'd0);
      check("rst_rdata",  rdata,       32'd0);
      @(posedge clk);
      #1;
      check("rst_rvalid_hold", 32'(rvalid), 32'd0);
      check("rst_ready_hold",  32'(ready),  32'd0);
      rst_n     = 1'b1;
      init_left = NWORD;
      exp_rdata = 32'd0;
      for (int i = 0; i < NBYTE; i++) mem_m[i] = 8'h00;
   endtask

   initial begin
      rst_n = 1'b1; req = 1'b0; we = 1'b0; addr = '0; size = 2'b00; uns = 1'b0;
      wdata = 32'd0; init_left = NWORD; exp_rdata = 32'd0;
      #2;
      do_reset();

      // Stores issued during the sweep must be dropped. Ready is checked on
      // every cycle.
      for (int i = 0; i < NWORD; i++) step(1'b1, 1'b1, 6'h00, 2'b10, 1'b0, 32'hFFFF_FFFF);
      step(1'b1, 1'b0, 6'h00, 2'b10, 1'b0, 32'd0);
      check("init_drop", rdata, 32'h0000_0000);
      for (int i = 0; i < NWORD; i++) begin
         step(1'b1, 1'b0, 6'(4*i), 2'b10, 1'b0, 32'd0);
         check("clear_word", rdata, 32'h0000_0000);
      end

      // Extraction and sign/zero extension of bytes and halves.
      step(1'b1, 1'b1, 6'h08, 2'b10, 1'b0, 32'h80FF_7F01);
      step(1'b1, 1'b0, 6'h08, 2'b00, 1'b0, 32'd0); check("lb8",   rdata, 32'h0000_0001);
      step(1'b1, 1'b0, 6'h09, 2'b00, 1'b0, 32'd0); check("lb9",   rdata, 32'h0000_007F);
      step(1'b1, 1'b0, 6'h0A, 2'b00, 1'b0, 32'd0); check("lbA",   rdata, 32'hFFFF_FFFF);
      step(1'b1, 1'b0, 6'h0B, 2'b00, 1'b1, 32'd0); check("lbuB",  rdata, 32'h0000_0080);
      step(1'b1, 1'b0, 6'h0A, 2'b01, 1'b0, 32'd0); check("lhA",   rdata, 32'hFFFF_80FF);
      step(1'b1, 1'b0, 6'h0A, 2'b01, 1'b1, 32'd0); check("lhuA",  rdata, 32'h0000_80FF);

      // Back-to-back partial stores, then a load right behind them.
      step(1'b1, 1'b1, 6'h04, 2'b10, 1'b0, 32'h0000_0000);
      step(1'b1, 1'b1, 6'h06, 2'b00, 1'b0, 32'h0000_00AB);
      step(1'b1, 1'b1, 6'h04, 2'b01, 1'b0, 32'h0000_1234);
      step(1'b1, 1'b0, 6'h04, 2'b10, 1'b0, 32'd0); check("b2b_lw", rdata, 32'h00AB_1234);
      check("b2b_rvalid", 32'(rvalid), 32'd1);

      // Rejected requests must leave memory unchanged.
      step(1'b1, 1'b1, 6'h00, 2'b10, 1'b0, 32'h1122_3344);
      step(1'b1, 1'b1, 6'h03, 2'b01, 1'b0, 32'hDEAD_BEEF); check("fault_sh3", 32'(fault), 32'd1);
      step(1'b1, 1'b1, 6'h02, 2'b10, 1'b0, 32'hDEAD_BEEF); check("fault_sw2", 32'(fault), 32'd1);
      step(1'b1, 1'b1, 6'h00, 2'b11, 1'b0, 32'hDEAD_BEEF); check("fault_sz3", 32'(fault), 32'd1);
      step(1'b0, 1'b0, 6'h00, 2'b10, 1'b0, 32'd0);        check("fault_end", 32'(fault), 32'd0);
      step(1'b1, 1'b0, 6'h00, 2'b10, 1'b0, 32'd0);        check("fault_keep", rdata, 32'h1122_3344);

      // Randomized traffic. Size 11 is kept occasional.
      for (int i = 0; i < 600; i++) begin
         int unsigned sel;
         sel = $urandom_range(0, 7);
         step(bit'($urandom_range(0, 9) < 8), bit'($urandom_range(0, 1)), 6'($urandom_range(0, NBYTE-1)),
              (sel == 7) ? 2'b11 : 2'(sel % 3), bit'($urandom_range(0, 1)), $urandom);
      end

      // Reset while a load response is showing cuts the pulse short.
      step(1'b1, 1'b0, 6'h08, 2'b10, 1'b0, 32'd0);
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 6'h00, 2'b10, 1'b0, 32'd0);

      // Reset mid-sweep with a load waiting before the edge. No response
      // comes, and the sweep starts over.
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = 6'h04; size = 2'b10; uns = 1'b0;
      #2;
      do_reset();
      for (int i = 0; i < NWORD; i++) step(1'b0, 1'b0, 6'h00, 2'b10, 1'b0, 32'd0);
      step(1'b1, 1'b0, 6'h04, 2'b10, 1'b0, 32'd0); check("resweep_lw4", rdata, 32'h0000_0000);
      step(1'b1, 1'b0, 6'h00, 2'b10, 1'b0, 32'd0); check("resweep_lw0", rdata, 32'h0000_0000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
